// File: rtl/dm_access_pkg.sv
// dm_access_pkg: shared definitions for the data-memory access controller.
//   - load/store op encodings carried on req_op
//   - FSM state enum
//   - merge_store(): builds the word written back by a sub-word store
package dm_access_pkg;

  localparam logic [2:0] OP_WORD = 3'b000;
  localparam logic [2:0] OP_LB   = 3'b001;
  localparam logic [2:0] OP_LBU  = 3'b010;
  localparam logic [2:0] OP_LH   = 3'b011;
  localparam logic [2:0] OP_LHU  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_MERGE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic is_byte(input logic [2:0] op);
    return (op == OP_LB) || (op == OP_LBU);
  endfunction

  function automatic logic is_half(input logic [2:0] op);
    return (op == OP_LH) || (op == OP_LHU);
  endfunction

  // Replace the addressed byte/halfword of old_word with the low bits of wdata.
  // Word ops (or anything else) return old_word untouched.
  function automatic logic [31:0] merge_store(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  off,
                                              input logic [2:0]  op);
    logic [31:0] w;
    w = old_word;
    if (is_byte(op)) begin
      case (off)
        2'd0:    w[7:0]   = wdata[7:0];
        2'd1:    w[15:8]  = wdata[7:0];
        2'd2:    w[23:16] = wdata[7:0];
        default: w[31:24] = wdata[7:0];
      endcase
    end else if (is_half(op)) begin
      if (off[1]) w[31:16] = wdata[15:0];
      else        w[15:0]  = wdata[15:0];
    end
    return w;
  endfunction

endpackage

// File: rtl/dm_access_if.sv
// Bus bundles for dm_access_ctrl.
//   dm_req_if : CPU memory-stage request/response handshake
//               master = requester (CPU), slave = controller
//   dm_mem_if : single-port synchronous-read data memory
//               master = controller, slave = memory
interface dm_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_op, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_op, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

interface dm_mem_if #(
  parameter int ADDR_W = 12
);
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dm_load_extend.sv
// dm_load_extend: combinational lane select and sign/zero extension for loads.
//   addr_lo : byte offset within the word
//   op      : load op (word / byte s/u / half s/u)
//   word    : raw memory word
//   data    : right-aligned, extended load result
module dm_load_extend
  import dm_access_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  op,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    case (op)
      OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  data = {24'h0, byte_sel};
      OP_LH:   data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  data = {16'h0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: sequencer between the CPU memory stage and a word-wide,
// synchronous-read data memory without byte enables. One request in flight;
// sub-word stores are done as read-modify-write; misaligned/illegal requests
// respond with an error and never touch memory.
//   clk, rst : clock, synchronous active-high reset
//   req      : dm_req_if.slave  (valid/ready request, one-cycle response pulse)
//   mem      : dm_mem_if.master (mem_rdata valid the cycle after a read strobe)
//
//   state    | meaning
//   ---------+------------------------------------------------
//   ST_IDLE  | ready; accepts and issues the first memory access
//   ST_LOAD  | read data returning, load response this cycle
//   ST_MERGE | RMW write of the merged word
//   ST_DONE  | store or error response
module dm_access_ctrl
  import dm_access_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic     clk,
  input  logic     rst,
  dm_req_if.slave  req,
  dm_mem_if.master mem
);

  state_t            state;
  logic [2:0]        op_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       wdata_q;
  logic              err_q;

  logic              ready;
  logic              accept;
  logic              req_err;
  logic              word_store;
  logic              in_merge;
  logic [31:0]       load_data;

  assign ready      = (state == ST_IDLE) && !rst;
  assign accept     = req.req_valid && ready;
  assign req_err    = (req.req_op > OP_LHU)
                   || (is_half(req.req_op) && req.req_addr[0])
                   || ((req.req_op == OP_WORD) && (req.req_addr[1:0] != 2'b00));
  assign word_store = req.req_we && (req.req_op == OP_WORD);
  assign in_merge   = (state == ST_MERGE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      op_q    <= OP_WORD;
      off_q   <= 2'b00;
      waddr_q <= '0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q    <= req.req_op;
            off_q   <= req.req_addr[1:0];
            waddr_q <= req.req_addr[ADDR_W+1:2];
            wdata_q <= req.req_wdata;
            err_q   <= req_err;
            if (req_err || word_store) state <= ST_DONE;
            else if (req.req_we)       state <= ST_MERGE;
            else                       state <= ST_LOAD;
          end
        end
        ST_LOAD:  state <= ST_IDLE;
        ST_MERGE: state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  dm_load_extend u_load_extend (
    .addr_lo (off_q),
    .op      (op_q),
    .word    (mem.mem_rdata),
    .data    (load_data)
  );

  // Strobes in the accept cycle come straight from the request so the first
  // access costs no extra cycle; later ones use the latched copy.
  always_comb begin
    mem.mem_en    = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = 32'h0;
    if (accept) begin
      mem.mem_addr = req.req_addr[ADDR_W+1:2];
      if (!req_err) begin
        mem.mem_en = 1'b1;
        if (word_store) begin
          mem.mem_we    = 1'b1;
          mem.mem_wdata = req.req_wdata;
        end
      end
    end else if (!rst) begin
      mem.mem_addr = waddr_q;
      if (in_merge) begin
        mem.mem_en    = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_wdata = merge_store(mem.mem_rdata, wdata_q, off_q, op_q);
      end
    end
  end

  assign req.req_ready  = ready;
  assign req.resp_valid = ((state == ST_LOAD) || (state == ST_DONE)) && !rst;
  assign req.resp_err   = (state == ST_DONE) && err_q && !rst;
  assign req.resp_rdata = ((state == ST_LOAD) && !rst) ? load_data : 32'h0;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl with a behavioural synchronous-read memory.
module tb_dm_access_ctrl;
  import dm_access_pkg::*;

  localparam int ADDR_W = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b1;
  always #5 clk = ~clk;

  dm_req_if                     req_if ();
  dm_mem_if #(.ADDR_W(ADDR_W))  mem_if ();

  dm_access_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .req (req_if.slave),
    .mem (mem_if.master)
  );

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  always @(posedge clk) begin
    if (preload) mem[4] <= 32'h8899AABB;
    else if (mem_if.mem_en) begin
      if (mem_if.mem_we) mem[mem_if.mem_addr] <= mem_if.mem_wdata;
      else               mem_if.mem_rdata <= mem[mem_if.mem_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_if.req_valid = 1'b1;
    req_if.req_we    = we;
    req_if.req_op    = op;
    req_if.req_addr  = addr;
    req_if.req_wdata = wdata;
  endtask

  // Garbage on the fields after accept checks that the controller latched them.
  task automatic idle_in();
    req_if.req_valid = 1'b0;
    req_if.req_we    = 1'b0;
    req_if.req_op    = 3'b111;
    req_if.req_addr  = 32'hFFFF_FFFF;
    req_if.req_wdata = 32'h5A5A_5A5A;
  endtask

  task automatic load_test(input string tag, input logic [2:0] op,
                           input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk); drive(1'b0, op, addr, 32'h0);
    #1;
    chk({tag, ".ready"},  req_if.req_ready, 1);
    chk({tag, ".en"},     mem_if.mem_en, 1);
    chk({tag, ".we"},     mem_if.mem_we, 0);
    chk({tag, ".addr"},   mem_if.mem_addr, addr[13:2]);
    @(negedge clk); idle_in();
    #1;
    chk({tag, ".rvalid"}, req_if.resp_valid, 1);
    chk({tag, ".rerr"},   req_if.resp_err, 0);
    chk({tag, ".rdata"},  req_if.resp_rdata, exp);
    chk({tag, ".busy"},   req_if.req_ready, 0);
  endtask

  task automatic sub_store_test(input string tag, input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_word);
    @(negedge clk); drive(1'b1, op, addr, wdata);
    #1;
    chk({tag, ".rd_en"},  mem_if.mem_en, 1);
    chk({tag, ".rd_we"},  mem_if.mem_we, 0);
    @(negedge clk); idle_in();
    #1;
    chk({tag, ".wr_en"},  mem_if.mem_en, 1);
    chk({tag, ".wr_we"},  mem_if.mem_we, 1);
    chk({tag, ".wr_addr"}, mem_if.mem_addr, addr[13:2]);
    chk({tag, ".wr_data"}, mem_if.mem_wdata, exp_word);
    chk({tag, ".early"},  req_if.resp_valid, 0);
    @(negedge clk);
    #1;
    chk({tag, ".rvalid"}, req_if.resp_valid, 1);
    chk({tag, ".rerr"},   req_if.resp_err, 0);
    chk({tag, ".rdata"},  req_if.resp_rdata, 0);
  endtask

  task automatic err_test(input string tag, input logic [2:0] op, input logic [31:0] addr);
    @(negedge clk); drive(1'b0, op, addr, 32'h0);
    #1;
    chk({tag, ".en"},     mem_if.mem_en, 0);
    @(negedge clk); idle_in();
    #1;
    chk({tag, ".rvalid"}, req_if.resp_valid, 1);
    chk({tag, ".rerr"},   req_if.resp_err, 1);
    chk({tag, ".rdata"},  req_if.resp_rdata, 0);
    chk({tag, ".en2"},    mem_if.mem_en, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] acc;
    logic [5:0] rsp;

    // Request presented during reset must not be accepted.
    drive(1'b0, OP_WORD, 32'h10, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst.ready", req_if.req_ready, 0);
    chk("rst.en",    mem_if.mem_en, 0);
    chk("rst.we",    mem_if.mem_we, 0);
    chk("rst.rvalid", req_if.resp_valid, 0);
    @(negedge clk);
    rst = 1'b0; preload = 1'b0; idle_in();
    #1;
    chk("rel.ready", req_if.req_ready, 1);
    chk("rel.rvalid", req_if.resp_valid, 0);
    chk("rel.rerr",  req_if.resp_err, 0);
    chk("rel.rdata", req_if.resp_rdata, 0);
    chk("rel.en",    mem_if.mem_en, 0);
    chk("rel.we",    mem_if.mem_we, 0);
    chk("rel.addr",  mem_if.mem_addr, 0);
    chk("rel.wdata", mem_if.mem_wdata, 0);

    load_test("lb13",  OP_LB,   32'h13, 32'hFFFF_FF88);
    load_test("lbu13", OP_LBU,  32'h13, 32'h0000_0088);
    load_test("lh10",  OP_LH,   32'h10, 32'hFFFF_AABB);
    load_test("lhu12", OP_LHU,  32'h12, 32'h0000_8899);
    load_test("lw10",  OP_WORD, 32'h10, 32'h8899_AABB);

    sub_store_test("sb11", OP_LB, 32'h11, 32'h1234_56CC, 32'h8899_CCBB);
    load_test("lw_sb", OP_WORD, 32'h10, 32'h8899_CCBB);
    sub_store_test("sh12", OP_LH, 32'h12, 32'h0000_BEEF, 32'hBEEF_CCBB);
    load_test("lw_sh", OP_WORD, 32'h10, 32'hBEEF_CCBB);

    // Word store: write in the accept cycle, response next cycle.
    @(negedge clk); drive(1'b1, OP_WORD, 32'h10, 32'hDEAD_BEEF);
    #1;
    chk("sw.en",    mem_if.mem_en, 1);
    chk("sw.we",    mem_if.mem_we, 1);
    chk("sw.wdata", mem_if.mem_wdata, 32'hDEAD_BEEF);
    @(negedge clk); idle_in();
    #1;
    chk("sw.rvalid", req_if.resp_valid, 1);
    chk("sw.rerr",   req_if.resp_err, 0);
    chk("sw.rdata",  req_if.resp_rdata, 0);
    chk("sw.en2",    mem_if.mem_en, 0);
    load_test("lw_sw", OP_WORD, 32'h10, 32'hDEAD_BEEF);

    err_test("err_lw12", OP_WORD, 32'h12);
    err_test("err_lh11", OP_LH,   32'h11);
    err_test("err_op7",  3'b111,  32'h10);

    // Reset landing on the MERGE cycle of a byte store.
    @(negedge clk); drive(1'b1, OP_LB, 32'h10, 32'h0000_0077);
    #1;
    chk("rstm.rd_en", mem_if.mem_en, 1);
    @(negedge clk); idle_in(); rst = 1'b1;
    #1;
    chk("rstm.we",     mem_if.mem_we, 0);
    chk("rstm.en",     mem_if.mem_en, 0);
    chk("rstm.rvalid", req_if.resp_valid, 0);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rstm.ready",  req_if.req_ready, 1);
    chk("rstm.rvalid2", req_if.resp_valid, 0);
    @(negedge clk);
    #1;
    chk("rstm.rvalid3", req_if.resp_valid, 0);
    chk("rstm.memword", mem[4], 32'hDEAD_BEEF);
    load_test("lw_rstm", OP_WORD, 32'h10, 32'hDEAD_BEEF);

    // req_valid held high: accepts every other cycle.
    acc = '0; rsp = '0;
    @(negedge clk); drive(1'b0, OP_WORD, 32'h10, 32'h0);
    for (int i = 0; i < 6; i++) begin
      #1;
      acc[i] = req_if.req_ready;
      rsp[i] = req_if.resp_valid;
      @(negedge clk);
    end
    idle_in();
    chk("b2b.accepts", {26'h0, acc}, 32'h15);
    chk("b2b.resps",   {26'h0, rsp}, 32'h2A);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_access_ctrl.md
# dm_access_ctrl

Sequencer between the CPU memory stage and a single-port, word-wide, synchronous-read data memory without byte enables. Accepts one load/store request at a time over a valid/ready handshake. Loads return a sign- or zero-extended byte, halfword or word. Sub-word stores are done as read-modify-write. Misaligned or illegal requests are flagged as errors and never touch memory.

## Interface
- ADDR_W, 12, data-memory word-address width (memory holds 2^ADDR_W words)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_op  in  3  000 word, 001 byte signed, 010 byte unsigned, 011 half signed, 100 half unsigned; for stores, 001/010 = byte and 011/100 = half
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  qualifies resp_valid: misaligned or illegal op
- resp_rdata  out  32  extended load data; 0 whenever not (resp_valid && load && !resp_err)
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  word address = req_addr[ADDR_W+1:2]
- mem_wdata  out  32  write word
- mem_rdata  in  32  read data, valid the cycle after mem_en && !mem_we

## Operation
- States:
  - IDLE
  - LOAD: read data returning
  - MERGE: RMW write
  - DONE: store or error response
- Accept occurs when req_valid && req_ready. All request fields are latched at accept, so requesters hold them only for that cycle.
- Error check at accept:
  - op 101–111 → error
  - half with addr[0] = 1 → error
  - word with addr[1:0] ≠ 00 → error
  - On error: no mem_en, go to DONE, resp_err = 1.
- Accept behaviour by request type (memory strobes are combinational from the accept in the same cycle):
  - Load: mem_en = 1, mem_we = 0; go to LOAD.
  - Word store: mem_en = 1, mem_we = 1, mem_wdata = req_wdata; go to DONE.
  - Sub-word store: mem_en = 1, mem_we = 0 (read); go to MERGE.
- LOAD:
  - Select a byte using addr[1:0], or a halfword using addr[1]; word passes through.
  - Extend per op and drive resp_rdata combinationally from mem_rdata.
  - resp_valid = 1; go to IDLE.
- MERGE:
  - mem_en = mem_we = 1, same address.
  - mem_wdata = mem_rdata with the addressed byte replaced by wdata[7:0], or the addressed halfword replaced by wdata[15:0].
  - Go to DONE.
- DONE: resp_valid = 1, resp_err as latched, resp_rdata = 0; go to IDLE.

## Timing
- Accept in cycle N. resp_valid is asserted in:
  - load: N+1
  - word store: N+1
  - error: N+1
  - sub-word store: N+2
- req_ready = 0 outside IDLE. Back-to-back throughput:
  - one request every 2 cycles (load, word store, error)
  - one request every 3 cycles (sub-word store)
- Reset values: state IDLE, req_ready 1 from the cycle after rst deasserts, resp_valid 0, resp_err 0, resp_rdata 0, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0.
- Memory strobes are gated by !rst.
- rst during LOAD or DONE: the response is suppressed.
- rst during MERGE: no write is issued; the memory word stays unchanged.
- A request presented while rst = 1 is not accepted.
- req_valid dropping outside IDLE is ignored. No request is ever dropped once accepted, except by reset.

## Structure
- Package dm_access_pkg:
  - op encodings (OP_WORD, OP_LB, OP_LBU, OP_LH, OP_LHU)
  - state enum
  - function merge_store(old_word, wdata, addr[1:0], op)
- Sub-module dm_load_extend: combinational select and extend; inputs addr[1:0], op, 32-bit word; output 32-bit data.
- Everything else (FSM, latched request registers, error check) lives in dm_access_ctrl.

## Test plan
Memory word 4 (byte address 0x10) is preloaded with 0x8899AABB.
- lb @0x13: resp_valid at N+1, resp_rdata 0xFFFFFF88. lbu @0x13 → 0x00000088.
- lh @0x10 → 0xFFFFAABB. lhu @0x12 → 0x00008899. lw @0x10 → 0x8899AABB.
- sb @0x11, wdata 0x123456CC:
  - read at N; write 0x8899CCBB at N+1; resp_valid at N+2.
  - A following lw @0x10 returns 0x8899CCBB.
- sh @0x12, wdata 0x0000BEEF: stored word 0xBEEFCCBB. sw @0x10 of 0xDEADBEEF: write at N, resp_valid at N+1.
- Error cases, each giving resp_err = 1 at N+1, mem_en never high, resp_rdata 0:
  - lw @0x12
  - lh @0x11
  - op 111
- rst = 1 in the MERGE cycle of sb @0x10: no mem_we, word unchanged, no resp_valid, req_ready 1 afterwards.
- req_valid held high for 3 loads: accepts at N, N+2, N+4.
